// File: rtl/seq_counter_param.sv
// seq_counter_param: stepped index 0..seq_len (up/down, wrapping) mapped to binary/Gray/table/one-hot code.
// Latency: q, idx and wrap are registered and update on the same clk edge as the step.
// No backpressure: en steps once per edge, load overrides en, table writes are independent.
// Optional feature macro SEQ_COUNTER_ONESHOT_EN adds oneshot/done (hold at terminal index instead of wrap).

module seq_counter_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [IW-1:0]    load_idx,
    input  logic [IW-1:0]    seq_len,
    input  logic [1:0]       mode,
    input  logic             tbl_we,
    input  logic [IW-1:0]    tbl_addr,
    input  logic [WIDTH-1:0] tbl_data,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             wrap
`ifdef SEQ_COUNTER_ONESHOT_EN
    ,
    input  logic             oneshot,
    output logic             done
`endif
);

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_GRAY = 2'b01;
    localparam logic [1:0] MODE_TBL  = 2'b10;
    localparam logic [1:0] MODE_OH   = 2'b11;

    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] r_tbl [DEPTH];

    logic [IW-1:0]    w_idx_nxt;
    logic             w_wrap_nxt;
    logic             w_wrap_step;   // this edge's step crosses the sequence boundary
    logic [IW-1:0]    w_wrap_tgt;    // where a wrapping step lands
    logic [WIDTH-1:0] w_tbl_rd;
    logic [WIDTH-1:0] w_q_nxt;

`ifdef SEQ_COUNTER_ONESHOT_EN
    logic             r_done;
    logic [IW-1:0]    w_term;        // terminal index a one-shot step parks on
`endif

    // Map an index to the output code; table entry is supplied by the caller.
    function automatic logic [WIDTH-1:0] f_map(
        input logic [IW-1:0]    n,
        input logic [1:0]       m,
        input logic [WIDTH-1:0] t
    );
        logic [WIDTH+IW-1:0] ext;
        logic [WIDTH-1:0]    bin;
        logic [WIDTH-1:0]    res;
        ext = {{WIDTH{1'b0}}, n};
        bin = ext[WIDTH-1:0];
        res = '0;
        case (m)
            MODE_BIN:  res = bin;
            MODE_GRAY: res = bin ^ (bin >> 1);
            MODE_TBL:  res = t;
            MODE_OH:   res = (int'(n) < WIDTH) ? (WIDTH'(1) << n) : '0;
            default:   res = '0;
        endcase
        return res;
    endfunction

    // Next index and wrap decision: load beats en beats hold.
    always_comb begin
        w_idx_nxt   = r_idx;
        w_wrap_nxt  = 1'b0;
        w_wrap_step = 1'b0;
        w_wrap_tgt  = '0;
`ifdef SEQ_COUNTER_ONESHOT_EN
        w_term      = dir ? seq_len : '0;
`endif
        if (load) begin
            w_idx_nxt = (load_idx > seq_len) ? seq_len : load_idx;
        end else if (en) begin
            if (dir) begin
                if (r_idx < seq_len) begin
                    w_idx_nxt = r_idx + IW'(1);
                end else begin
                    // at L, or beyond L after seq_len was lowered
                    w_wrap_step = 1'b1;
                    w_wrap_tgt  = '0;
                end
            end else begin
                if (r_idx == '0 || r_idx > seq_len) begin
                    w_wrap_step = 1'b1;
                    w_wrap_tgt  = seq_len;
                end else begin
                    w_idx_nxt = r_idx - IW'(1);
                end
            end
        end

        if (w_wrap_step) begin
`ifdef SEQ_COUNTER_ONESHOT_EN
            if (oneshot) begin
                w_idx_nxt = w_term;
            end else begin
                w_idx_nxt  = w_wrap_tgt;
                w_wrap_nxt = 1'b1;
            end
`else
            w_idx_nxt  = w_wrap_tgt;
            w_wrap_nxt = 1'b1;
`endif
        end
    end

    // Table read uses the pre-edge contents, giving read-before-write on a same-address write.
    always_comb begin
        w_tbl_rd = r_tbl[w_idx_nxt];
        w_q_nxt  = f_map(w_idx_nxt, mode, w_tbl_rd);
    end

    // Index, mapped code and wrap pulse registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_idx  <= '0;
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    // Sequence table: identity contents out of reset, runtime writable.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl[i] <= WIDTH'(i);
            end
        end else if (tbl_we) begin
            r_tbl[tbl_addr] <= tbl_data;
        end
    end

`ifdef SEQ_COUNTER_ONESHOT_EN
    // done latches on a suppressed wrap and is only released by load or clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_done <= 1'b0;
        end else if (load) begin
            r_done <= 1'b0;
        end else if (w_wrap_step && oneshot) begin
            r_done <= 1'b1;
        end
    end

    assign done = r_done;
`endif

    assign q    = r_q;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_seq_counter_param.sv
// Testbench for seq_counter_param: vector table plus hand-written clear/one-shot sequences.
// Expected outputs are queued when a vector is driven and popped one edge later.
// Runs to a single summary line; a watchdog bounds the run.

module tb_seq_counter_param;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic             clk = 1'b0;
    logic             clear;
    logic             en, dir, load, tbl_we;
    logic [IW-1:0]    load_idx, seq_len, tbl_addr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] tbl_data;
    logic [WIDTH-1:0] q;
    logic [IW-1:0]    idx;
    logic             wrap;
`ifdef SEQ_COUNTER_ONESHOT_EN
    logic             oneshot;
    logic             done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             ld;
        logic [IW-1:0]    lidx;
        logic             en;
        logic             dir;
        logic [IW-1:0]    len;
        logic [1:0]       mode;
        logic             we;
        logic [IW-1:0]    waddr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] eq;
        logic [IW-1:0]    eidx;
        logic             ewrap;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [IW-1:0]    idx;
        logic             wrap;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    seq_counter_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .dir      (dir),
        .load     (load),
        .load_idx (load_idx),
        .seq_len  (seq_len),
        .mode     (mode),
        .tbl_we   (tbl_we),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .q        (q),
        .idx      (idx),
        .wrap     (wrap)
`ifdef SEQ_COUNTER_ONESHOT_EN
        ,
        .oneshot  (oneshot),
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic ld, input int lidx, input logic e, input logic d,
                        input int len, input int m, input logic we, input int wa, input int wd,
                        input int eq, input int ei, input logic ew);
        vec_t v;
        v.ld = ld; v.lidx = IW'(lidx); v.en = e; v.dir = d; v.len = IW'(len);
        v.mode = 2'(m); v.we = we; v.waddr = IW'(wa); v.wdata = WIDTH'(wd);
        v.eq = WIDTH'(eq); v.eidx = IW'(ei); v.ewrap = ew;
        vecs.push_back(v);
    endtask

    // Drive one vector (called away from the edge), queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        load = v.ld; load_idx = v.lidx; en = v.en; dir = v.dir; seq_len = v.len;
        mode = v.mode; tbl_we = v.we; tbl_addr = v.waddr; tbl_data = v.wdata;
        e.q = v.eq; e.idx = v.eidx; e.wrap = v.ewrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s scoreboard: empty queue, expected 1 entry", tag);
        end else begin
            got = sb.pop_front();
            check({tag, " q"},    32'(q),    32'(got.q));
            check({tag, " idx"},  32'(idx),  32'(got.idx));
            check({tag, " wrap"}, 32'(wrap), 32'(got.wrap));
        end
    endtask

    task automatic step_args(input logic ld, input int lidx, input logic e, input logic d,
                             input int len, input int m, input int eq, input int ei,
                             input logic ew, input string tag);
        vec_t v;
        v.ld = ld; v.lidx = IW'(lidx); v.en = e; v.dir = d; v.len = IW'(len);
        v.mode = 2'(m); v.we = 1'b0; v.waddr = '0; v.wdata = '0;
        v.eq = WIDTH'(eq); v.eidx = IW'(ei); v.ewrap = ew;
        step(v, tag);
    endtask

    initial begin
        int gray_q [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
        int tq [4]     = '{9, 3, 12, 6};
        int dq [5]     = '{6, 12, 3, 9, 6};
        int di [5]     = '{3, 2, 1, 0, 3};

        clear = 1'b1;
        en = 1'b0; dir = 1'b0; load = 1'b0; tbl_we = 1'b0;
        load_idx = '0; seq_len = '0; tbl_addr = '0; mode = 2'b00; tbl_data = '0;
`ifdef SEQ_COUNTER_ONESHOT_EN
        oneshot = 1'b0;
`endif

        // binary, L=5, up 7 steps: wrap only after 5->0
        for (int i = 1; i <= 7; i++) begin
            int n;
            n = i % 6;
            addv(0, 0, 1, 1, 5, 0, 0, 0, 0, n, n, (i == 6));
        end
        // Gray, L=15, up 8 from 0
        addv(1, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) addv(0, 0, 1, 1, 15, 1, 0, 0, 0, gray_q[i], i + 1, 0);
        // table writes while holding at idx 8 (Gray 12)
        for (int i = 0; i < 4; i++) addv(0, 0, 0, 0, 15, 1, 1, i, tq[i], 12, 8, 0);
        // table mode, L=3, down from 0
        addv(1, 0, 0, 0, 3, 2, 0, 0, 0, 9, 0, 0);
        for (int i = 0; i < 5; i++) addv(0, 0, 1, 0, 3, 2, 0, 0, 0, dq[i], di[i], (i == 0 || i == 4));
        // load clamps to L and beats en; lowered L while down-stepping wraps to L
        addv(1, 10, 1, 1, 7, 0, 0, 0, 0, 7, 7, 0);
        addv(0, 0, 1, 0, 4, 0, 0, 0, 0, 4, 4, 1);
        // seq_len = 0: every step wraps, idx stays 0
        addv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        addv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        addv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // one-hot including n >= WIDTH, then mode remap without stepping
        addv(1, 2, 0, 0, 7, 3, 0, 0, 0, 4, 2, 0);
        addv(0, 0, 1, 1, 7, 3, 0, 0, 0, 8, 3, 0);
        addv(0, 0, 1, 1, 7, 3, 0, 0, 0, 0, 4, 0);
        addv(0, 0, 0, 0, 7, 0, 0, 0, 0, 4, 4, 0);
        addv(0, 0, 0, 0, 7, 1, 0, 0, 0, 6, 4, 0);
        // read-before-write on the current table address
        addv(1, 1, 0, 0, 3, 2, 0, 0, 0, 3, 1, 0);
        addv(0, 0, 0, 0, 3, 2, 1, 1, 15, 3, 1, 0);
        addv(0, 0, 0, 0, 3, 2, 0, 0, 0, 15, 1, 0);

        #12;
        clear = 1'b0;
        #1;
        check("reset q",    32'(q),    32'd0);
        check("reset idx",  32'(idx),  32'd0);
        check("reset wrap", 32'(wrap), 32'd0);
        @(negedge clk);

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // asynchronous clear between edges at idx 6
        step_args(1, 6, 0, 0, 7, 0, 6, 6, 0, "clr_pre");
        #2;
        clear = 1'b1;
        #1;
        check("clear async q",   32'(q),   32'd0);
        check("clear async idx", 32'(idx), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        step_args(0, 0, 1, 1, 7, 0, 1, 1, 0, "clr_up");
        step_args(1, 2, 0, 0, 7, 2, 2, 2, 0, "clr_tbl2");

`ifdef SEQ_COUNTER_ONESHOT_EN
        // one-shot: hold at L instead of wrapping, done latches until load
        step_args(1, 0, 0, 0, 3, 0, 0, 0, 0, "os_load");
        oneshot = 1'b1;
        step_args(0, 0, 1, 1, 3, 0, 1, 1, 0, "os1");
        check("os1 done", 32'(done), 32'd0);
        step_args(0, 0, 1, 1, 3, 0, 2, 2, 0, "os2");
        check("os2 done", 32'(done), 32'd0);
        step_args(0, 0, 1, 1, 3, 0, 3, 3, 0, "os3");
        step_args(0, 0, 1, 1, 3, 0, 3, 3, 0, "os4");
        check("os4 done", 32'(done), 32'd1);
        step_args(0, 0, 1, 1, 3, 0, 3, 3, 0, "os5");
        check("os5 done", 32'(done), 32'd1);
        step_args(1, 1, 0, 0, 3, 0, 1, 1, 0, "os_reload");
        check("os_reload done", 32'(done), 32'd0);
        oneshot = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
